// File: rtl/conv_sched_pkg.sv
// Shared constants, state encoding and configuration check for the conv tile scheduler.
package conv_sched_pkg;

    localparam int DATA_W       = 16;
    localparam int FILT_WORDS   = 9;
    localparam int LEN_W        = 32;
    localparam int TILE_W       = 16;
    localparam int MIN_TILE_LEN = 9;
    localparam int FILT_AW      = $clog2(FILT_WORDS);

    localparam logic [DATA_W/8-1:0] TKEEP_ALL = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILT  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // A job needs at least one tile and whole 3-word rows of at least three rows.
    function automatic logic cfg_ok(input logic [TILE_W-1:0] num_tiles,
                                    input logic [LEN_W-1:0]  tile_len);
        return (num_tiles != '0) &&
               (tile_len >= LEN_W'(MIN_TILE_LEN)) &&
               ((tile_len % LEN_W'(3)) == '0);
    endfunction

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// Stream bundle between the scheduler, its two DMA sources, the conv engine and the result snoop.
// Every stream uses AXIS valid/ready: a beat moves only in a cycle where TVALID and TREADY are both 1.
interface conv_tile_scheduler_if;
    import conv_sched_pkg::*;

    logic              F_AXIS_TVALID;
    logic [DATA_W-1:0] F_AXIS_TDATA;
    logic              F_AXIS_TREADY;

    logic              D_AXIS_TVALID;
    logic [DATA_W-1:0] D_AXIS_TDATA;
    logic              D_AXIS_TREADY;

    logic                M_AXIS_TVALID;
    logic [DATA_W-1:0]   M_AXIS_TDATA;
    logic [DATA_W/8-1:0] M_AXIS_TKEEP;
    logic                M_AXIS_TLAST;
    logic                M_AXIS_TREADY;

    logic R_AXIS_TVALID;
    logic R_AXIS_TREADY;
    logic R_AXIS_TLAST;

    modport master (
        input  F_AXIS_TVALID, F_AXIS_TDATA,
        output F_AXIS_TREADY,
        input  D_AXIS_TVALID, D_AXIS_TDATA,
        output D_AXIS_TREADY,
        output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
        input  M_AXIS_TREADY,
        input  R_AXIS_TVALID, R_AXIS_TREADY, R_AXIS_TLAST
    );

    modport slave (
        output F_AXIS_TVALID, F_AXIS_TDATA,
        input  F_AXIS_TREADY,
        output D_AXIS_TVALID, D_AXIS_TDATA,
        input  D_AXIS_TREADY,
        input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
        output M_AXIS_TREADY,
        output R_AXIS_TVALID, R_AXIS_TREADY, R_AXIS_TLAST
    );

endinterface

// File: rtl/conv_filter_cache.sv
// FILT_WORDS x DATA_W register file holding tile 0's filter for replay on later tiles.
// Only built when FILTER_REUSE_EN is defined.
`ifdef FILTER_REUSE_EN
module conv_filter_cache
    import conv_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [FILT_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [FILT_AW-1:0] rd_addr,
    output logic [DATA_W-1:0]  rd_data
);

    logic [DATA_W-1:0] mem_q [FILT_WORDS];
    logic [DATA_W-1:0] mem_d [FILT_WORDS];

    always_comb begin
        for (int i = 0; i < FILT_WORDS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en && (wr_addr < FILT_AW'(FILT_WORDS))) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FILT_WORDS; i++) begin
            if (rst) mem_q[i] <= '0;
            else     mem_q[i] <= mem_d[i];
        end
    end

    assign rd_data = (rd_addr < FILT_AW'(FILT_WORDS)) ? mem_q[rd_addr] : '0;

endmodule
`endif

// File: rtl/conv_tile_scheduler.sv
// Sequences filter + data packets per tile into the conv engine, waiting for each result TLAST.
// Define FILTER_REUSE_EN to capture tile 0's filter and replay it locally for later tiles.
module conv_tile_scheduler
    import conv_sched_pkg::*;
(
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESET,
    input  logic              cfg_start,
    input  logic [TILE_W-1:0] cfg_num_tiles,
    input  logic [LEN_W-1:0]  cfg_tile_len,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [TILE_W-1:0] tile_idx,
    output state_t            dbg_state,
    conv_tile_scheduler_if.master axis
);

    state_t            state_q,     state_d;
    logic [TILE_W-1:0] tile_idx_q,  tile_idx_d;
    logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
    logic [LEN_W-1:0]  tile_len_q,  tile_len_d;
    logic [LEN_W-1:0]  beat_cnt_q,  beat_cnt_d;
    logic              done_q,      done_d;
    logic              cfg_err_q,   cfg_err_d;

    logic              m_valid, m_last, f_ready, d_ready, advance;
    logic [DATA_W-1:0] m_data;
    logic              filt_last, data_last, last_tile, r_last;

`ifdef FILTER_REUSE_EN
    logic              cache_we;
    logic [DATA_W-1:0] cache_rd_data;

    conv_filter_cache u_cache (
        .clk     (AXIS_ACLK),
        .rst     (AXIS_ARESET),
        .wr_en   (cache_we),
        .wr_addr (beat_cnt_q[FILT_AW-1:0]),
        .wr_data (axis.F_AXIS_TDATA),
        .rd_addr (beat_cnt_q[FILT_AW-1:0]),
        .rd_data (cache_rd_data)
    );
`endif

    assign filt_last = (beat_cnt_q == LEN_W'(FILT_WORDS - 1));
    assign data_last = (beat_cnt_q == (tile_len_q - LEN_W'(1)));
    assign last_tile = (tile_idx_q == (num_tiles_q - TILE_W'(1)));
    assign r_last    = axis.R_AXIS_TVALID && axis.R_AXIS_TREADY && axis.R_AXIS_TLAST;

    always_comb begin
        state_d     = state_q;
        tile_idx_d  = tile_idx_q;
        num_tiles_d = num_tiles_q;
        tile_len_d  = tile_len_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        f_ready     = 1'b0;
        d_ready     = 1'b0;
        advance     = 1'b0;
`ifdef FILTER_REUSE_EN
        cache_we    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_ok(cfg_num_tiles, cfg_tile_len)) begin
                        state_d     = FILT;
                        num_tiles_d = cfg_num_tiles;
                        tile_len_d  = cfg_tile_len;
                        tile_idx_d  = '0;
                        beat_cnt_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FILT: begin
`ifdef FILTER_REUSE_EN
                if (tile_idx_q != '0) begin
                    m_valid = 1'b1;
                    m_data  = cache_rd_data;
                end else begin
                    m_valid  = axis.F_AXIS_TVALID;
                    m_data   = axis.F_AXIS_TDATA;
                    f_ready  = axis.M_AXIS_TREADY;
                    cache_we = axis.F_AXIS_TVALID && axis.M_AXIS_TREADY;
                end
`else
                m_valid = axis.F_AXIS_TVALID;
                m_data  = axis.F_AXIS_TDATA;
                f_ready = axis.M_AXIS_TREADY;
`endif
                m_last = filt_last;
                if (m_valid && axis.M_AXIS_TREADY) begin
                    if (filt_last) begin
                        state_d    = DATA;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            DATA: begin
                m_valid = axis.D_AXIS_TVALID;
                m_data  = axis.D_AXIS_TDATA;
                d_ready = axis.M_AXIS_TREADY;
                m_last  = data_last;
                if (m_valid && axis.M_AXIS_TREADY) begin
                    if (data_last) begin
                        // A result TLAST landing with the final data beat closes the tile now.
                        if (r_last) begin
                            advance = 1'b1;
                        end else begin
                            state_d    = DRAIN;
                            beat_cnt_d = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (r_last) advance = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            beat_cnt_d = '0;
            if (last_tile) begin
                state_d    = IDLE;
                tile_idx_d = '0;
                done_d     = 1'b1;
            end else begin
                state_d    = FILT;
                tile_idx_d = tile_idx_q + TILE_W'(1);
            end
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q     <= IDLE;
            tile_idx_q  <= '0;
            num_tiles_q <= '0;
            tile_len_q  <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_idx_q  <= tile_idx_d;
            num_tiles_q <= num_tiles_d;
            tile_len_q  <= tile_len_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign axis.M_AXIS_TVALID = m_valid;
    assign axis.M_AXIS_TDATA  = m_data;
    assign axis.M_AXIS_TKEEP  = TKEEP_ALL;
    assign axis.M_AXIS_TLAST  = m_last;
    assign axis.F_AXIS_TREADY = f_ready;
    assign axis.D_AXIS_TREADY = d_ready;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign tile_idx  = tile_idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Randomized bench for conv_tile_scheduler against a beat-list reference model of each job.
module tb_conv_tile_scheduler;
    import conv_sched_pkg::*;

`ifdef FILTER_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              cfg_start     = 1'b0;
    logic [TILE_W-1:0] cfg_num_tiles = '0;
    logic [LEN_W-1:0]  cfg_tile_len  = '0;
    logic              busy, done, cfg_err;
    logic [TILE_W-1:0] tile_idx;
    state_t            dbg_state;

    conv_tile_scheduler_if axis ();

    conv_tile_scheduler dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .cfg_start     (cfg_start),
        .cfg_num_tiles (cfg_num_tiles),
        .cfg_tile_len  (cfg_tile_len),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .tile_idx      (tile_idx),
        .dbg_state     (dbg_state),
        .axis          (axis)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        bit                is_data;
        bit                from_src;
        int                tile;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] fsrc_q[$];
    logic [DATA_W-1:0] dsrc_q[$];

    int n_chk = 0;
    int n_bad = 0;
    int res_cnt, dl_cnt, beats_acc;
    bit busy_exp, done_exp_next, f_hold, d_hold, stall_v;
    logic [DATA_W-1:0] stall_data;
    logic              stall_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        cfg_start          = 1'b0;
        axis.F_AXIS_TVALID = 1'b0;
        axis.F_AXIS_TDATA  = '0;
        axis.D_AXIS_TVALID = 1'b0;
        axis.D_AXIS_TDATA  = '0;
        axis.M_AXIS_TREADY = 1'b0;
        axis.R_AXIS_TVALID = 1'b0;
        axis.R_AXIS_TREADY = 1'b0;
        axis.R_AXIS_TLAST  = 1'b0;
    endtask

    // Reset with sources valid and sink ready, so a lingering ready/valid would show.
    task automatic reset_and_check();
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        axis.F_AXIS_TVALID = 1'b1;
        axis.D_AXIS_TVALID = 1'b1;
        axis.M_AXIS_TREADY = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_state",   dbg_state, IDLE);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_tile",    tile_idx, 0);
        check("rst_mvalid",  axis.M_AXIS_TVALID, 0);
        check("rst_mlast",   axis.M_AXIS_TLAST, 0);
        check("rst_fready",  axis.F_AXIS_TREADY, 0);
        check("rst_dready",  axis.D_AXIS_TREADY, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
    endtask

    task automatic bad_cfg(input int n, input int len);
        @(posedge clk); #1;
        idle_inputs();
        cfg_num_tiles      = TILE_W'(n);
        cfg_tile_len       = LEN_W'(len);
        cfg_start          = 1'b1;
        axis.F_AXIS_TVALID = 1'b1;
        axis.D_AXIS_TVALID = 1'b1;
        axis.M_AXIS_TREADY = 1'b1;
        @(negedge clk);
        check("bad_err_early", cfg_err, 0);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("bad_err_pulse", cfg_err, 1);
        check("bad_busy",      busy, 0);
        check("bad_fready",    axis.F_AXIS_TREADY, 0);
        check("bad_dready",    axis.D_AXIS_TREADY, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bad_err_clear", cfg_err, 0);
        check("bad_busy2",     busy, 0);
        idle_inputs();
    endtask

    // Expected engine stream for a whole job, plus what each source must supply.
    task automatic build_job(input int n, input int len);
        logic [DATA_W-1:0] f0 [FILT_WORDS];
        logic [DATA_W-1:0] w;
        exp_q.delete();
        fsrc_q.delete();
        dsrc_q.delete();
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < FILT_WORDS; k++) begin
                bit src = (t == 0) || !REUSE;
                if (src) begin
                    w = DATA_W'($urandom);
                    fsrc_q.push_back(w);
                end else begin
                    w = f0[k];
                end
                if (t == 0) f0[k] = w;
                exp_q.push_back('{data: w, last: (k == FILT_WORDS - 1), is_data: 1'b0,
                                  from_src: src, tile: t});
            end
            for (int k = 0; k < len; k++) begin
                w = DATA_W'($urandom);
                dsrc_q.push_back(w);
                exp_q.push_back('{data: w, last: (k == len - 1), is_data: 1'b1,
                                  from_src: 1'b1, tile: t});
            end
        end
    endtask

    // rmode: 0 sink always ready, 1 toggling, 2 random. abort_at >= 0 stops after that many beats.
    task automatic run_job(input int n, input int len, input int rmode, input int abort_at);
        bit pending, head_ok, e_mv, e_fr, e_dr, was_done, r_fire;
        int e_tile;
        @(posedge clk); #1;
        idle_inputs();
        cfg_num_tiles = TILE_W'(n);
        cfg_tile_len  = LEN_W'(len);
        cfg_start     = 1'b1;
        @(negedge clk);
        check("start_busy", busy, 0);
        check("start_err",  cfg_err, 0);
        build_job(n, len);
        res_cnt = 0; dl_cnt = 0; beats_acc = 0;
        busy_exp = 1'b1; done_exp_next = 1'b0;
        f_hold = 1'b0; d_hold = 1'b0; stall_v = 1'b0;

        for (int cyc = 0; ; cyc++) begin
            if (cyc >= 4000) begin
                check("job_timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
            cfg_start = 1'b0;
            if (busy_exp && $urandom_range(0, 15) == 0) begin
                cfg_start     = 1'b1;
                cfg_num_tiles = '0;
            end
            if (!f_hold) axis.F_AXIS_TVALID = (fsrc_q.size() > 0) && ($urandom_range(0, 3) != 0);
            axis.F_AXIS_TDATA = (fsrc_q.size() > 0) ? fsrc_q[0] : '0;
            if (!d_hold) axis.D_AXIS_TVALID = (dsrc_q.size() > 0) && ($urandom_range(0, 3) != 0);
            axis.D_AXIS_TDATA = (dsrc_q.size() > 0) ? dsrc_q[0] : '0;
            case (rmode)
                0:       axis.M_AXIS_TREADY = 1'b1;
                1:       axis.M_AXIS_TREADY = (cyc % 2 == 0);
                default: axis.M_AXIS_TREADY = ($urandom_range(0, 2) != 0);
            endcase
            pending = (dl_cnt > res_cnt);
            axis.R_AXIS_TVALID = 1'b0;
            axis.R_AXIS_TREADY = 1'b0;
            axis.R_AXIS_TLAST  = 1'b0;
            if (pending && $urandom_range(0, 2) == 0) begin
                axis.R_AXIS_TVALID = 1'b1;
                axis.R_AXIS_TLAST  = ($urandom_range(0, 3) != 0);
                axis.R_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            end else if (!pending && busy_exp && $urandom_range(0, 9) == 0) begin
                axis.R_AXIS_TVALID = 1'b1;
                axis.R_AXIS_TLAST  = 1'b1;
                axis.R_AXIS_TREADY = 1'b1;
            end
            #1;
            // Sometimes land the result TLAST on the very cycle of the last data beat.
            if (!pending && axis.D_AXIS_TREADY && axis.M_AXIS_TVALID && axis.M_AXIS_TLAST &&
                $urandom_range(0, 1) == 1) begin
                axis.R_AXIS_TVALID = 1'b1;
                axis.R_AXIS_TLAST  = 1'b1;
                axis.R_AXIS_TREADY = 1'b1;
            end

            @(negedge clk);
            head_ok = busy_exp && (exp_q.size() > 0) && (res_cnt >= exp_q[0].tile);
            e_mv = 1'b0; e_fr = 1'b0; e_dr = 1'b0;
            if (head_ok) begin
                if (exp_q[0].is_data) begin
                    e_mv = axis.D_AXIS_TVALID;
                    e_dr = axis.M_AXIS_TREADY;
                end else if (exp_q[0].from_src) begin
                    e_mv = axis.F_AXIS_TVALID;
                    e_fr = axis.M_AXIS_TREADY;
                end else begin
                    e_mv = 1'b1;
                end
            end
            check("m_tvalid", axis.M_AXIS_TVALID, e_mv);
            check("f_tready", axis.F_AXIS_TREADY, e_fr);
            check("d_tready", axis.D_AXIS_TREADY, e_dr);
            check("m_tkeep",  axis.M_AXIS_TKEEP, {(DATA_W/8){1'b1}});
            check("busy",     busy, busy_exp);
            check("done",     done, done_exp_next);
            check("cfg_err",  cfg_err, 0);
            if (busy_exp) begin
                if (exp_q.size() == 0) e_tile = n - 1;
                else                   e_tile = (exp_q[0].tile < res_cnt) ? exp_q[0].tile : res_cnt;
                check("tile_idx", tile_idx, e_tile);
            end
            if (stall_v) begin
                check("stall_data", axis.M_AXIS_TDATA, stall_data);
                check("stall_last", axis.M_AXIS_TLAST, stall_last);
            end
            if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY && exp_q.size() > 0) begin
                check(exp_q[0].is_data ? "d_beat" : "f_beat", axis.M_AXIS_TDATA, exp_q[0].data);
                check("m_tlast", axis.M_AXIS_TLAST, exp_q[0].last);
                if (exp_q[0].is_data && exp_q[0].last) dl_cnt++;
                void'(exp_q.pop_front());
                beats_acc++;
            end
            stall_v    = axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY;
            stall_data = axis.M_AXIS_TDATA;
            stall_last = axis.M_AXIS_TLAST;
            if (axis.F_AXIS_TVALID && axis.F_AXIS_TREADY && fsrc_q.size() > 0) void'(fsrc_q.pop_front());
            if (axis.D_AXIS_TVALID && axis.D_AXIS_TREADY && dsrc_q.size() > 0) void'(dsrc_q.pop_front());
            f_hold = axis.F_AXIS_TVALID && !axis.F_AXIS_TREADY;
            d_hold = axis.D_AXIS_TVALID && !axis.D_AXIS_TREADY;

            was_done      = done_exp_next;
            done_exp_next = 1'b0;
            r_fire = axis.R_AXIS_TVALID && axis.R_AXIS_TREADY && axis.R_AXIS_TLAST;
            if (r_fire && dl_cnt > res_cnt) begin
                res_cnt++;
                if (res_cnt == n) begin
                    busy_exp      = 1'b0;
                    done_exp_next = 1'b1;
                end
            end
            if (was_done) break;
            if (abort_at >= 0 && beats_acc == abort_at) break;
        end

        if (abort_at < 0) begin
            check("exp_drained", exp_q.size(), 0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("done_single", done, 0);
            check("idle_busy",   busy, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        reset_and_check();

        run_job(1, 27, 0, -1);
        run_job(1, 27, 1, -1);
        run_job(3, 9, 2, -1);

        bad_cfg(1, 10);
        bad_cfg(0, 27);
        bad_cfg(2, 6);

        run_job(1, 27, 0, FILT_WORDS + 5);
        reset_and_check();

        run_job(2, 12, 2, -1);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 3), 3 * $urandom_range(3, 10), $urandom_range(0, 2), -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
